score_keeper: RTL

Game-state controller that owns the two 4-bit player scores feeding the seven-segment score display. It counts points reported by the ball logic, holds the ball between rallies, and declares game over at the win score. It restarts the match on a start-button press. It sits between the ball/paddle collision logic (point pulses in) and the score display driver (score_p1/score_p2 in, which blanks and blinks once either score reaches 9).

---
 rtl/pong_pkg.sv | 16 +
 rtl/score_keeper_if.sv | 28 ++
 rtl/score_keeper_pause_timer.sv | 36 +++
 rtl/score_keeper.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared definitions for the pong game logic: FSM states, score width and
// default game constants used by both the score keeper and display driver.
package pong_pkg;

    localparam int SCORE_W          = 4;
    localparam int WIN_SCORE_DEF    = 9;
    localparam int PAUSE_CYCLES_DEF = 2 ** 20;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PAUSE     = 2'd1,
        PLAY      = 2'd2,
        GAME_OVER = 2'd3
    } game_state_t;

endpackage

// File: rtl/score_keeper_if.sv
// Signal bundle between the game environment (ball logic, start button,
// score display) and the score keeper.
interface score_keeper_if;
    import pong_pkg::*;

    logic               point_p1;
    logic               point_p2;
    logic               start;
    logic [SCORE_W-1:0] score_p1;
    logic [SCORE_W-1:0] score_p2;
    logic               ball_hold;
    logic               serve_p2;
    logic               game_over;
    logic               winner_p2;

    // Environment side: reports points and the start button, reads game state.
    modport master (
        output point_p1, point_p2, start,
        input  score_p1, score_p2, ball_hold, serve_p2, game_over, winner_p2
    );

    // Score keeper side.
    modport slave (
        input  point_p1, point_p2, start,
        output score_p1, score_p2, ball_hold, serve_p2, game_over, winner_p2
    );

endinterface

// File: rtl/score_keeper_pause_timer.sv
// Loadable down-counter that times the ball hold between rallies. After a
// load it counts down to zero and then raises done for exactly one cycle.
module pause_timer #(
    parameter int PAUSE_W = 21
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load,
    input  logic [PAUSE_W-1:0] load_value,
    output logic               done
);

    logic [PAUSE_W-1:0] count;
    logic               running;

    // done is decoded from registers only; running drops the cycle done is seen.
    assign done = running && (count == '0);

    // Count down from the loaded value; a load always wins over expiry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count   <= '0;
            running <= 1'b0;
        end else if (load) begin
            count   <= load_value;
            running <= 1'b1;
        end else if (running) begin
            if (count == '0) begin
                running <= 1'b0;
            end else begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/score_keeper.sv
// Game-state controller: owns both player scores, holds the ball between
// rallies, detects the winning point and restarts the match on start.
module score_keeper
    import pong_pkg::*;
#(
    parameter int WIN_SCORE    = WIN_SCORE_DEF,
    parameter int PAUSE_CYCLES = PAUSE_CYCLES_DEF,
    parameter int PAUSE_W      = 21
) (
    input  logic          clk,
    input  logic          reset_n,
    score_keeper_if.slave bus
);

    localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);
    localparam logic [PAUSE_W-1:0] PAUSE_LOAD = PAUSE_W'(PAUSE_CYCLES - 1);

    game_state_t        state_q, state_d;
    logic [SCORE_W-1:0] score_p1_q, score_p1_d;
    logic [SCORE_W-1:0] score_p2_q, score_p2_d;
    logic               serve_q, serve_d;
    logic               winner_q, winner_d;
    logic               start_q;
    logic               start_rise;
    logic               timer_load;
    logic               timer_done;
    logic [SCORE_W-1:0] inc_p1;
    logic [SCORE_W-1:0] inc_p2;

    // start_q resets high so a button held through reset is not a press.
    assign start_rise = bus.start && !start_q;
    assign inc_p1     = score_p1_q + 1'b1;
    assign inc_p2     = score_p2_q + 1'b1;

    pause_timer #(
        .PAUSE_W(PAUSE_W)
    ) u_pause_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (timer_load),
        .load_value(PAUSE_LOAD),
        .done      (timer_done)
    );

    // State, score and serve registers plus the start edge detector.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            score_p1_q <= '0;
            score_p2_q <= '0;
            serve_q    <= 1'b0;
            winner_q   <= 1'b0;
            start_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            score_p1_q <= score_p1_d;
            score_p2_q <= score_p2_d;
            serve_q    <= serve_d;
            winner_q   <= winner_d;
            start_q    <= bus.start;
        end
    end

    // Next-state, scoring and timer-load decisions.
    always_comb begin
        state_d    = state_q;
        score_p1_d = score_p1_q;
        score_p2_d = score_p2_q;
        serve_d    = serve_q;
        winner_d   = winner_q;
        timer_load = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_rise) begin
                    timer_load = 1'b1;
                    state_d    = PAUSE;
                end
            end

            PAUSE: begin
                if (timer_done) begin
                    state_d = PLAY;
                end
            end

            PLAY: begin
                unique case ({bus.point_p1, bus.point_p2})
                    2'b11: begin
                        // A let: nobody scores, the rally is replayed.
                        timer_load = 1'b1;
                        state_d    = PAUSE;
                    end
                    2'b10: begin
                        score_p1_d = inc_p1;
                        serve_d    = 1'b1;
                        if (inc_p1 == WIN_VAL) begin
                            winner_d = 1'b0;
                            state_d  = GAME_OVER;
                        end else begin
                            timer_load = 1'b1;
                            state_d    = PAUSE;
                        end
                    end
                    2'b01: begin
                        score_p2_d = inc_p2;
                        serve_d    = 1'b0;
                        if (inc_p2 == WIN_VAL) begin
                            winner_d = 1'b1;
                            state_d  = GAME_OVER;
                        end else begin
                            timer_load = 1'b1;
                            state_d    = PAUSE;
                        end
                    end
                    default: begin
                    end
                endcase
            end

            GAME_OVER: begin
                if (start_rise) begin
                    score_p1_d = '0;
                    score_p2_d = '0;
                    serve_d    = !winner_q;
                    timer_load = 1'b1;
                    state_d    = PAUSE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.score_p1  = score_p1_q;
    assign bus.score_p2  = score_p2_q;
    assign bus.serve_p2  = serve_q;
    assign bus.winner_p2 = winner_q;
    assign bus.ball_hold = (state_q != PLAY);
    assign bus.game_over = (state_q == GAME_OVER);

endmodule
